// File: rtl/pc_hazard_controller.sv
// PC sequencing and hazard control for the pipelined MIPS core: next-PC selection,
// load-use stalls, instruction-memory stall handling and deferred branch/jump redirects.
module pc_hazard_controller #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             imem_ready,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    WAIT       = 2'd2,
    WAIT_REDIR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PC_INC  = {{(WIDTH-3){1'b0}}, 3'b100};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] redir_r;
  logic [WIDTH-1:0] redir_nxt_s;
  logic             hazard_s;
  logic             hazard_eff_s;
  logic             redirect_s;
  logic [WIDTH-1:0] tgt_s;
  logic [WIDTH-1:0] pc_plus4_s;

  // Derived hazard/redirect terms; detection is masked for the single LU_STALL cycle.
  always_comb begin
    hazard_s     = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    hazard_eff_s = hazard_s && (state_r != LU_STALL);
    redirect_s   = jump || branch_taken;
    tgt_s        = jump ? jump_target : branch_target;
    pc_plus4_s   = pc + PC_INC;
  end

  // State and captured redirect target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      redir_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      redir_r <= redir_nxt_s;
    end
  end

  // Next-state logic; WAIT with memory ready is resolved exactly like RUN.
  always_comb begin
    state_nxt_s = state_r;
    redir_nxt_s = redir_r;
    case (state_r)
      RUN, LU_STALL, WAIT: begin
        if (!imem_ready) begin
          if ((state_r != WAIT) && redirect_s && !hazard_eff_s) begin
            state_nxt_s = WAIT_REDIR;
            redir_nxt_s = tgt_s;
          end else begin
            state_nxt_s = WAIT;
          end
        end else if (hazard_eff_s) begin
          state_nxt_s = LU_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      WAIT_REDIR: begin
        if (imem_ready) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = WAIT_REDIR;
        end
      end
      default: begin
        state_nxt_s = RUN;
        redir_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control outputs act in the same cycle; reset forces the PC to RESET_PC and frozen.
  always_comb begin
    next_pc      = pc;
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst_n) begin
      next_pc   = RESET_PC;
      pc_freeze = 1'b1;
    end else begin
      case (state_r)
        RUN, LU_STALL, WAIT: begin
          if (!imem_ready) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            next_pc      = pc;
          end else if (hazard_eff_s) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_bubble = 1'b1;
            next_pc      = pc;
          end else if (redirect_s) begin
            next_pc     = tgt_s;
            if_id_flush = 1'b1;
          end else begin
            next_pc = pc_plus4_s;
          end
        end
        WAIT_REDIR: begin
          if (imem_ready) begin
            next_pc     = redir_r;
            if_id_flush = 1'b1;
          end else begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            next_pc      = pc;
          end
        end
        default: begin
          pc_freeze    = 1'b1;
          if_id_freeze = 1'b1;
          next_pc      = pc;
        end
      endcase
    end
  end

  // Saturating count of frozen-PC cycles for performance debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (pc_freeze && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: doc/pc_hazard_controller.md
Name: pc_hazard_controller

Overview:
- Sequences the program counter register and the IF/ID and ID/EX pipeline registers of the pipelined MIPS core.
- Computes next_pc (sequential, branch or jump target) and the PC freeze control.
- Detects load-use hazards, waits out instruction-memory stalls, and holds a branch/jump redirect that arrives during a memory stall until fetch can resume.
- Sits between ID-stage decode and the PC / IF/ID registers. Keeps a saturating stall counter for performance debug.

Parameters:
- WIDTH, 32, address width of the PC and its targets.
- RESET_PC, 32'h0000_0000, value driven on next_pc while in reset.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  WIDTH  current PC register output.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  5  load destination register.
- if_id_rs  in  5  source register rs of the instruction in ID.
- if_id_rt  in  5  source register rt of the instruction in ID.
- branch_taken  in  1  ID resolved a taken branch.
- branch_target  in  WIDTH  branch target address.
- jump  in  1  ID holds a jump.
- jump_target  in  WIDTH  jump target address.
- next_pc  out  WIDTH  value for the PC input.
- pc_freeze  out  1  1 = PC holds its value.
- if_id_freeze  out  1  1 = IF/ID register holds its value.
- if_id_flush  out  1  1 = IF/ID register loads a NOP.
- id_ex_bubble  out  1  1 = ID/EX register loads a NOP.
- stall_count  out  CNT_W  number of cycles in which pc_freeze was 1.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0:
  - state=RUN, redir_q=0, stall_count=0.
  - next_pc=RESET_PC, pc_freeze=1, all other control outputs 0.
  - Reset asserted mid-stall discards any pending redirect.
- Control outputs are combinational from state and inputs, and act in the same cycle. State, redir_q and stall_count update on the rising clk edge.
- Derived signals:
  - hazard = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
  - redirect = jump | branch_taken.
  - tgt = jump ? jump_target : branch_target. Jump wins if both are asserted.
- pc+4 is computed modulo 2^WIDTH, so 32'hFFFF_FFFC wraps to 0.
- State RUN, priority highest first:
  1. imem_ready=0:
     - Outputs: pc_freeze=1, if_id_freeze=1, next_pc=pc.
     - If redirect=1 and hazard=0: redir_q<=tgt, go to WAIT_REDIR. Otherwise go to WAIT.
  2. hazard=1:
     - Outputs: pc_freeze=1, if_id_freeze=1, id_ex_bubble=1, next_pc=pc.
     - Any redirect is ignored this cycle, because the branch operands are not yet valid.
     - Go to LU_STALL.
  3. redirect=1: next_pc=tgt, if_id_flush=1, pc_freeze=0. Stay in RUN.
  4. Otherwise: next_pc=pc+4, pc_freeze=0.
- State LU_STALL (exactly one cycle):
  - Hazard detection is masked. Redirect is evaluated as in RUN items 3-4.
  - imem_ready=0 behaves as in RUN item 1.
  - Otherwise go to RUN.
- State WAIT:
  - While imem_ready=0: freeze PC and IF/ID, next_pc=pc.
  - When imem_ready=1: evaluate as RUN in the same cycle.
- State WAIT_REDIR:
  - While imem_ready=0: freeze PC and IF/ID, next_pc=pc. New redirect inputs are ignored; the first captured target wins.
  - When imem_ready=1: next_pc=redir_q, if_id_flush=1, pc_freeze=0, go to RUN.
- if_id_flush and if_id_freeze are never 1 in the same cycle.
- stall_count increments on every clk edge where pc_freeze=1 and rst_n=1. It saturates at 2^CNT_W-1 and does not wrap.
- Latency: a redirect takes effect on the first edge on which the fetch is not frozen. In that case exactly one wrong-path fetch is flushed.

Test Plan:
- Reset: rst_n=0 mid-run with pc=32'h40 → next_pc=0, pc_freeze=1, stall_count=0. After release with pc=0 and no hazards → next_pc=32'h4.
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 → one cycle with pc_freeze=1, id_ex_bubble=1, next_pc=pc. Next cycle with the same inputs (LU_STALL masks detection) → next_pc=pc+4, stall_count=1. Repeating with id_ex_rt=0 → no stall.
- Branch: branch_taken=1, branch_target=32'h100 while jump=1, jump_target=32'h200 → next_pc=32'h200, if_id_flush=1, pc_freeze=0.
- Redirect during memory stall: imem_ready=0, branch_taken=1, target 32'h80, held 3 cycles (target changed to 32'hC0 in cycle 2) → pc_freeze=1 for 3 cycles. When imem_ready=1 → next_pc=32'h80, if_id_flush=1, stall_count=3.
- Hazard plus branch: hazard=1 and branch_taken=1 together → stall with no flush. Next cycle → redirect applied.
- Wrap and saturation: pc=32'hFFFF_FFFC → next_pc=0. With CNT_W=4, hold imem_ready=0 for 20 cycles → stall_count stops at 15.
